piso_bit_serializer: RTL and testbench

PISO_BIT_SERIALIZER -- requirements
Module: piso_bit_serializer

---
 rtl/piso_bit_serializer.sv | 120 ++++++++++++
 tb/tb_piso_bit_serializer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_bit_serializer.sv
// Parallel-in serial-out bit serializer with a one-word holding buffer so that
// back-to-back words stream out with no idle bit between them.
module piso_bit_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             d_out,
  output logic             bit_valid,
  output logic             last_bit,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state_q, state_n;
  logic [CW-1:0]    cnt_q, cnt_n;
  logic [WIDTH-1:0] shreg_q, shreg_n;
  logic [WIDTH-1:0] hold_q, hold_n;
  logic             hold_full_q, hold_full_n;
  logic             d_out_n, bit_valid_n, last_bit_n, busy_n;
  logic             accept;

  // The bit currently presented always sits at the shifter's output end.
  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  assign din_ready = ~hold_full_q & ~rst;
  assign accept    = din_valid & din_ready;

  // Next-state, datapath and registered-output values.
  always_comb begin
    state_n     = state_q;
    cnt_n       = cnt_q;
    shreg_n     = shreg_q;
    hold_n      = hold_q;
    hold_full_n = hold_full_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          shreg_n = din;
          cnt_n   = '0;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q != LAST_CNT) begin
          shreg_n = shift_word(shreg_q);
          cnt_n   = cnt_q + CW'(1);
          if (accept) begin
            hold_n      = din;
            hold_full_n = 1'b1;
          end
        end else begin
          // Final bit: refill from the buffer first, then from din, else drain.
          cnt_n = '0;
          if (hold_full_q) begin
            shreg_n     = hold_q;
            hold_full_n = 1'b0;
          end else if (accept) begin
            shreg_n = din;
          end else begin
            shreg_n = '0;
            state_n = IDLE;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    bit_valid_n = (state_n == SHIFT);
    d_out_n     = bit_valid_n ? head_bit(shreg_n) : IDLE_BIT;
    last_bit_n  = bit_valid_n && (cnt_n == LAST_CNT);
    busy_n      = bit_valid_n | hold_full_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      d_out       <= IDLE_BIT;
      bit_valid   <= 1'b0;
      last_bit    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_n;
      cnt_q       <= cnt_n;
      shreg_q     <= shreg_n;
      hold_q      <= hold_n;
      hold_full_q <= hold_full_n;
      d_out       <= d_out_n;
      bit_valid   <= bit_valid_n;
      last_bit    <= last_bit_n;
      busy        <= busy_n;
    end
  end

endmodule

// File: tb/tb_piso_bit_serializer.sv
// Randomized self-checking bench for piso_bit_serializer against a bit-queue model.
module tb_piso_bit_serializer;

  localparam int unsigned W = 8;

  logic         clk, rst;
  logic [W-1:0] din, din1;
  logic         din_valid, din_valid1;
  logic         din_ready, d_out, bit_valid, last_bit, busy;
  logic         din_ready_l, d_out_l, bit_valid_l, last_bit_l, busy_l;

  int tests, fails;

  // Model: every accepted word becomes W queued bits; one bit leaves per edge.
  bit   bq[$];
  bit   lq[$];
  logic exp_valid, exp_dout, exp_last, exp_busy, exp_ready;

  piso_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .d_out(d_out), .bit_valid(bit_valid), .last_bit(last_bit), .busy(busy)
  );

  piso_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .din(din1), .din_valid(din_valid1), .din_ready(din_ready_l),
    .d_out(d_out_l), .bit_valid(bit_valid_l), .last_bit(last_bit_l), .busy(busy_l)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // More than one word of pending bits means a word waits in the holding buffer.
  function void compute_exp();
    exp_valid = (bq.size() != 0);
    exp_dout  = exp_valid ? bq[0] : 1'b0;
    exp_last  = exp_valid ? lq[0] : 1'b0;
    exp_busy  = exp_valid;
    exp_ready = !rst && (bq.size() <= W);
  endfunction

  task automatic advance();
    bit           acc;
    logic [W-1:0] w;
    compute_exp();
    acc = din_valid && exp_ready;
    w   = din;
    @(posedge clk);
    if (rst) begin
      bq.delete();
      lq.delete();
    end else begin
      if (bq.size() != 0) begin
        void'(bq.pop_front());
        void'(lq.pop_front());
      end
      if (acc) begin
        for (int k = 0; k < W; k++) begin
          bq.push_back(w[W-1-k]);
          lq.push_back(k == W - 1);
        end
      end
    end
    #1;
  endtask

  task automatic settle();
    #1;
    compute_exp();
  endtask

  task automatic test_reset();
    rst = 1'b1; din_valid = 1'b1; din = W'($urandom);
    advance();
    for (int i = 0; i < 2; i++) begin
      settle();
      tests++;
      if ({din_ready, busy, bit_valid, last_bit, d_out} !== {exp_ready, exp_busy, exp_valid, exp_last, exp_dout}) begin
        fails++;
        $display("FAIL reset_hold: got %b want %b", {din_ready, busy, bit_valid, last_bit, d_out},
                 {exp_ready, exp_busy, exp_valid, exp_last, exp_dout});
      end
      advance();
    end
    rst = 1'b0; din_valid = 1'b0;
    settle();
    tests++;
    if ({din_ready, busy, bit_valid, last_bit, d_out} !== 5'b10000) begin
      fails++;
      $display("FAIL reset_release: got %b want 10000", {din_ready, busy, bit_valid, last_bit, d_out});
    end
    advance();
  endtask

  task automatic test_single();
    logic [W-1:0] cap;
    int nvalid, last_pos;
    cap = '0; nvalid = 0; last_pos = -1;
    din = 8'hA5; din_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      settle();
      tests++;
      if ({din_ready, busy, bit_valid, last_bit, d_out} !== {exp_ready, exp_busy, exp_valid, exp_last, exp_dout}) begin
        fails++;
        $display("FAIL single_cycle%0d: got %b want %b", c, {din_ready, busy, bit_valid, last_bit, d_out},
                 {exp_ready, exp_busy, exp_valid, exp_last, exp_dout});
      end
      if (bit_valid) begin
        cap = {cap[W-2:0], d_out};
        nvalid++;
        if (last_bit) last_pos = c;
      end
      advance();
      din_valid = 1'b0;
    end
    tests++;
    if (cap !== 8'hA5 || nvalid != 8 || last_pos != 8) begin
      fails++;
      $display("FAIL single_word: got %h/%0d bits/last@%0d want a5/8 bits/last@8", cap, nvalid, last_pos);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] cap;
    logic [3:0]  win;
    int nvalid, hits, nbits;
    bit ended, gap;
    cap = '0; win = '0; nvalid = 0; hits = 0; nbits = 0; ended = 0; gap = 0;
    for (int c = 0; c < 22; c++) begin
      din_valid = (c < 2);
      din       = (c == 0) ? 8'h0A : 8'h05;
      settle();
      tests++;
      if ({din_ready, busy, bit_valid, last_bit, d_out} !== {exp_ready, exp_busy, exp_valid, exp_last, exp_dout}) begin
        fails++;
        $display("FAIL b2b_cycle%0d: got %b want %b", c, {din_ready, busy, bit_valid, last_bit, d_out},
                 {exp_ready, exp_busy, exp_valid, exp_last, exp_dout});
      end
      if (bit_valid) begin
        if (ended) gap = 1;
        cap = {cap[14:0], d_out};
        win = {win[2:0], d_out};
        nvalid++; nbits++;
        if (nbits >= 4 && win == 4'b1010) hits++;
      end else if (nvalid != 0) begin
        ended = 1;
      end
      advance();
    end
    tests++;
    if (cap !== 16'h0A05 || nvalid != 16 || gap) begin
      fails++;
      $display("FAIL b2b_stream: got %h/%0d bits/gap=%0d want 0a05/16 bits/gap=0", cap, nvalid, gap);
    end
    tests++;
    if (hits != 1) begin
      fails++;
      $display("FAIL b2b_detect: got %0d pattern hits want 1", hits);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] w[3];
    logic [23:0]  cap;
    int idx, nvalid, stalls;
    for (int i = 0; i < 3; i++) w[i] = W'($urandom);
    idx = 0; cap = '0; nvalid = 0; stalls = 0;
    for (int c = 0; c < 40; c++) begin
      din_valid = (idx < 3);
      settle();
      din = (idx < 3 && exp_ready) ? w[idx] : W'($urandom);
      tests++;
      if ({din_ready, busy, bit_valid, last_bit, d_out} !== {exp_ready, exp_busy, exp_valid, exp_last, exp_dout}) begin
        fails++;
        $display("FAIL bp_cycle%0d: got %b want %b", c, {din_ready, busy, bit_valid, last_bit, d_out},
                 {exp_ready, exp_busy, exp_valid, exp_last, exp_dout});
      end
      if (idx < 3 && !din_ready) stalls++;
      if (bit_valid) begin
        cap = {cap[22:0], d_out};
        nvalid++;
      end
      if (din_valid && exp_ready) idx++;
      advance();
    end
    din_valid = 1'b0;
    tests++;
    if (idx != 3 || cap !== {w[0], w[1], w[2]} || nvalid != 24 || stalls == 0) begin
      fails++;
      $display("FAIL bp_stream: got %h/%0d bits/%0d words/%0d stalls want %h/24 bits/3 words/stalls>0",
               cap, nvalid, idx, stalls, {w[0], w[1], w[2]});
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] cap;
    int nvalid;
    cap = '0; nvalid = 0;
    for (int c = 0; c < 4; c++) begin
      din_valid = (c < 2);
      din       = (c == 0) ? 8'hFF : 8'h5A;
      rst       = (c == 3);
      settle();
      tests++;
      if ({din_ready, busy, bit_valid, last_bit, d_out} !== {exp_ready, exp_busy, exp_valid, exp_last, exp_dout}) begin
        fails++;
        $display("FAIL rmid_pre%0d: got %b want %b", c, {din_ready, busy, bit_valid, last_bit, d_out},
                 {exp_ready, exp_busy, exp_valid, exp_last, exp_dout});
      end
      advance();
    end
    rst = 1'b0; din_valid = 1'b0;
    settle();
    tests++;
    if (bit_valid !== 1'b0 || busy !== 1'b0 || din_ready !== 1'b1) begin
      fails++;
      $display("FAIL rmid_after: got valid=%b busy=%b ready=%b want 0 0 1", bit_valid, busy, din_ready);
    end
    din = 8'h3C; din_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      settle();
      tests++;
      if ({din_ready, busy, bit_valid, last_bit, d_out} !== {exp_ready, exp_busy, exp_valid, exp_last, exp_dout}) begin
        fails++;
        $display("FAIL rmid_post%0d: got %b want %b", c, {din_ready, busy, bit_valid, last_bit, d_out},
                 {exp_ready, exp_busy, exp_valid, exp_last, exp_dout});
      end
      if (bit_valid) begin
        cap = {cap[W-2:0], d_out};
        nvalid++;
      end
      advance();
      din_valid = 1'b0;
    end
    tests++;
    if (cap !== 8'h3C || nvalid != 8) begin
      fails++;
      $display("FAIL rmid_word: got %h/%0d bits want 3c/8 bits", cap, nvalid);
    end
  endtask

  task automatic test_lsb_first();
    logic [W-1:0] word, cap, want;
    int nvalid;
    for (int t = 0; t < 2; t++) begin
      word = (t == 0) ? 8'h01 : W'($urandom);
      want = (t == 0) ? 8'h80 : '0;
      if (t != 0) for (int k = 0; k < W; k++) want[W-1-k] = word[k];
      cap = '0; nvalid = 0;
      din1 = word; din_valid1 = 1'b1;
      advance();
      din_valid1 = 1'b0;
      for (int c = 0; c < 10; c++) begin
        settle();
        if (bit_valid_l) begin
          cap = {cap[W-2:0], d_out_l};
          nvalid++;
        end else begin
          tests++;
          if (d_out_l !== 1'b0) begin
            fails++;
            $display("FAIL lsb_idle_bit: got %b want 0", d_out_l);
          end
        end
        advance();
      end
      tests++;
      if (cap !== want || nvalid != 8) begin
        fails++;
        $display("FAIL lsb_word%0d: din %h got %h/%0d bits want %h/8 bits", t, word, cap, nvalid, want);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst       = ($urandom_range(0, 59) == 0);
      din_valid = ($urandom_range(0, 2) != 0);
      din       = W'($urandom);
      settle();
      tests++;
      if ({din_ready, busy, bit_valid, last_bit, d_out} !== {exp_ready, exp_busy, exp_valid, exp_last, exp_dout}) begin
        fails++;
        $display("FAIL random_cycle%0d: got %b want %b", c, {din_ready, busy, bit_valid, last_bit, d_out},
                 {exp_ready, exp_busy, exp_valid, exp_last, exp_dout});
      end
      advance();
    end
    rst = 1'b0; din_valid = 1'b0;
  endtask

  initial begin
    tests = 0; fails = 0;
    rst = 1'b1; din = '0; din_valid = 1'b0; din1 = '0; din_valid1 = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_lsb_first();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
